// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner producing a hex key code and key-present flag
// Ports: clk, reset (async, active-low), col_n[3:0] raw columns (low = closed),
//        row_n[3:0] one-hot active-low row drive, key_code[3:0] held key, key_pressed.
// Optional: define KEYPAD_GHOST_REJECT_EN to ignore multi-key samples while scanning.
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_pressed
);
  typedef enum logic {SCAN, HOLD} state_t;
  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);
  // nibble {row,col} -> code; row0 col0 is the least significant nibble
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  state_t     state, state_d;
  logic [3:0] col_m, col_s;
  logic [1:0] row_idx, row_idx_d, row_next, low_col;
  logic [7:0] settle_cnt, settle_d, rel_cnt, rel_d;
  logic [3:0] row_n_d, code_d, col_low;
  logic       pressed_d, any_low, key_seen;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= SCAN;
      col_m       <= 4'hF;
      col_s       <= 4'hF;
      row_idx     <= 2'd0;
      row_n       <= 4'b1110;
      settle_cnt  <= 8'd0;
      rel_cnt     <= 8'd0;
      key_code    <= 4'h0;
      key_pressed <= 1'b0;
    end else begin
      state       <= state_d;
      col_m       <= col_n;
      col_s       <= col_m;
      row_idx     <= row_idx_d;
      row_n       <= row_n_d;
      settle_cnt  <= settle_d;
      rel_cnt     <= rel_d;
      key_code    <= code_d;
      key_pressed <= pressed_d;
    end
  always_comb begin
    col_low  = ~col_s;
    any_low  = |col_low;
`ifdef KEYPAD_GHOST_REJECT_EN
    key_seen = any_low & ~|(col_low & (col_low - 4'd1));
`else
    key_seen = any_low;
`endif
    low_col   = col_low[0] ? 2'd0 : col_low[1] ? 2'd1 : col_low[2] ? 2'd2 : 2'd3;
    row_next  = row_idx + 2'd1;
    state_d   = state;
    row_idx_d = row_idx;
    row_n_d   = row_n;
    settle_d  = settle_cnt;
    rel_d     = rel_cnt;
    code_d    = key_code;
    pressed_d = key_pressed;
    if (state == SCAN) begin
      if (settle_cnt != LAST)
        settle_d = settle_cnt + 8'd1;
      else if (key_seen) begin
        state_d   = HOLD;
        code_d    = KEYMAP[{row_idx, low_col, 2'b00} +: 4];
        pressed_d = 1'b1;
        settle_d  = 8'd0;
        rel_d     = 8'd0;
      end else begin
        row_idx_d = row_next;
        row_n_d   = ~(4'b0001 << row_next);
        settle_d  = 8'd0;
      end
    end else begin
      if (any_low)
        rel_d = 8'd0;
      else if (rel_cnt == LAST) begin
        state_d   = SCAN;
        pressed_d = 1'b0;
        row_idx_d = row_next;
        row_n_d   = ~(4'b0001 << row_next);
        settle_d  = 8'd0;
        rel_d     = 8'd0;
      end else
        rel_d = rel_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a combinational keypad model
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col_n, row_n, key_code;
  logic       key_pressed;
  logic [3:0] pressed [4];
  logic [3:0] exp_q [$];
  int vectors = 0;
  int errors = 0;
  keypad_scanner #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .col_n(col_n),
    .row_n(row_n), .key_code(key_code), .key_pressed(key_pressed)
  );
  always #5 clk = ~clk;
  always_comb begin
    col_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
  end
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic align(input logic [3:0] pat);
    logic [3:0] prev;
    int n = 0;
    do begin
      prev = row_n;
      tick();
      n++;
    end while (!(row_n === pat && prev !== pat) && n < 40);
    vectors++;
    if (row_n !== pat) begin
      errors++;
      $display("FAIL align: row_n %b expected %b", row_n, pat);
    end
  endtask
  task automatic wait_detect(input string name, input int bound);
    int n = 0;
    logic [3:0] e;
    while (key_pressed !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 4'hx;
    vectors++;
    if (key_pressed !== 1'b1) begin
      errors++;
      $display("FAIL %s: key_pressed %b after %0d cycles expected 1", name, key_pressed, n);
    end else if (key_code !== e) begin
      errors++;
      $display("FAIL %s: key_code %h expected %h", name, key_code, e);
    end
  endtask
  task automatic wait_release(input string name, input int bound);
    int n = 0;
    while (key_pressed !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    vectors++;
    if (key_pressed !== 1'b0) begin
      errors++;
      $display("FAIL %s: key_pressed %b expected 0", name, key_pressed);
    end
  endtask
  task automatic check_outs(input string name, input logic [3:0] rn, input logic [3:0] kc, input logic kp);
    vectors++;
    if (row_n !== rn || key_code !== kc || key_pressed !== kp) begin
      errors++;
      $display("FAIL %s: row_n/key_code/key_pressed %b/%h/%b expected %b/%h/%b",
               name, row_n, key_code, key_pressed, rn, kc, kp);
    end
  endtask
  task automatic test_reset();
    tick();
    tick();
    check_outs("reset_initial", 4'b1110, 4'h0, 1'b0);
    reset = 1'b1;
    repeat (6) tick();
    check_outs("reset_prescan", 4'b1101, 4'h0, 1'b0);
    #2 reset = 1'b0;
    #1 check_outs("reset_async", 4'b1110, 4'h0, 1'b0);
    repeat (3) tick();
    check_outs("reset_held", 4'b1110, 4'h0, 1'b0);
    reset = 1'b1;
  endtask
  task automatic test_idle();
    logic [3:0] e;
    for (int k = 1; k <= 20; k++) begin
      tick();
      e = ~(4'b0001 << ((k / 4) % 4));
      check_outs($sformatf("idle_%0d", k), e, 4'h0, 1'b0);
    end
  endtask
  task automatic test_press5();
    align(4'b1011);
    pressed[1][1] = 1'b1;
    exp_q.push_back(4'h5);
    wait_detect("press5", 17);
    repeat (8) tick();
    check_outs("hold5", 4'b1101, 4'h5, 1'b1);
    pressed[1][1] = 1'b0;
    tick();
    tick();
    pressed[1][1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_outs($sformatf("glitch5_%0d", k), 4'b1101, 4'h5, 1'b1);
    end
  endtask
  task automatic test_release5();
    pressed[1][1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check_outs("release5_pre", 4'b1101, 4'h5, 1'b1);
      if (k == 6) check_outs("release5", 4'b1011, 4'h5, 1'b0);
    end
  endtask
  task automatic test_multi();
    int hits = 0;
    align(4'b1011);
    pressed[1][0] = 1'b1;
    pressed[1][2] = 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
    for (int k = 0; k < 24; k++) begin
      tick();
      hits += int'(key_pressed);
    end
    vectors++;
    if (hits != 0) begin
      errors++;
      $display("FAIL multi_ghost: key_pressed high for %0d cycles expected 0", hits);
    end
`else
    exp_q.push_back(4'h4);
    wait_detect("multi46", 17);
`endif
    pressed[1][0] = 1'b0;
    pressed[1][2] = 1'b0;
    wait_release("multi_release", 10);
  endtask
  task automatic test_hold0_then1();
    align(4'b1110);
    pressed[3][1] = 1'b1;
    exp_q.push_back(4'h0);
    wait_detect("press0", 17);
    pressed[0][0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k % 5 == 4) check_outs($sformatf("hold0_%0d", k), 4'b0111, 4'h0, 1'b1);
    end
    pressed[3][1] = 1'b0;
    wait_release("release0", 10);
    exp_q.push_back(4'h1);
    wait_detect("press1", 17);
    tick();
    check_outs("hold1", 4'b1110, 4'h1, 1'b1);
    #2 reset = 1'b0;
    #1 check_outs("reset_hold", 4'b1110, 4'h0, 1'b0);
    pressed[0][0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_outs("after_reset", 4'b1110, 4'h0, 1'b0);
  endtask
  initial begin
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    test_reset();
    test_idle();
    test_press5();
    test_release5();
    test_multi();
    test_hold0_then1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad and produces a 4-bit hex key code plus a key-present flag.
Sits directly upstream of the debouncer: key_code drives the debouncer's sig_in and key_pressed drives its key_pressed.
Drives one keypad row low at a time and samples the column lines through a 2-flop synchronizer.
Locks onto the first key found and holds until that key is released.

Parameters:
SETTLE_CYCLES, 4, clk cycles each row is driven before the columns are sampled; also the release-confirm length; legal range 3..255.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
col_n  input  4  raw keypad column lines; pulled up, low = key closed on the driven row; asynchronous to clk
row_n  output  4  row drive, one-hot active-low; bit r low = row r driven
key_code  output  4  hex code of the held key; valid while key_pressed=1
key_pressed  output  1  high while a key is locked and held

Behaviour:
- Reset (reset=0, async):
  - row_n=4'b1110; row index=0.
  - key_code=4'h0; key_pressed=0.
  - State=SCAN; settle counter=0; release counter=0.
  - Both synchronizer stages=4'b1111.
- All outputs are registered. No combinational path from col_n.
- Synchronizer: col_s is the second flop stage; latency is 2 cycles.
- Key map, [row][col] -> code:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- SCAN state:
  - Settle counter counts 0..SETTLE_CYCLES-1 with the current row driven.
  - At count==SETTLE_CYCLES-1 with col_s!=4'b1111:
    - Go to HOLD.
    - key_code <= map[row][lowest-index low column].
    - key_pressed <= 1 on the same edge.
    - row_n unchanged.
  - At count==SETTLE_CYCLES-1 with col_s==4'b1111:
    - Row index increments; 3 wraps to 0.
    - row_n rotates to the next row.
    - Counter clears.
- HOLD state:
  - row_n frozen; key_code frozen; key_pressed=1.
  - Release counter increments each cycle col_s==4'b1111 and clears on any low column.
  - When the release counter reaches SETTLE_CYCLES-1 while col_s is all-high, on that edge:
    - key_pressed <= 0.
    - State <= SCAN.
    - Row index advances to the next row (wrapping).
    - Settle and release counters clear.
  - key_code keeps its last value after release.
- Worst-case detection latency from a stable press: 4*SETTLE_CYCLES+1 cycles.
- Release latency: SETTLE_CYCLES cycles of all-high col_s, plus 2 synchronizer cycles.
- Boundary conditions:
  - Multiple keys on the sampled row: lowest column index wins.
  - Keys on other rows are invisible during HOLD because those rows are not driven.
  - A second key pressed on the held row during HOLD does not change key_code and does not extend the hold beyond its own press.
  - Reset asserted mid-HOLD: immediate return to reset values; no release sequence.
  - Key released before its row is sampled: not reported.

Optional Feature:
KEYPAD_GHOST_REJECT_EN
- Defined:
  - In SCAN, a sample with more than one low bit in col_s is treated as no key; the row advances and nothing is reported.
  - In HOLD, multiple lows count as "still pressed".
- Undefined: lowest-column-priority encoding as above.

Test Plan:
- Bench keypad model: combinational, col_n[c] = ~|(pressed[r][c] & ~row_n[r]). SETTLE_CYCLES=4 throughout.
- Reset: hold reset=0 mid-scan -> row_n=4'b1110, key_pressed=0, key_code=4'h0 immediately; stays so until reset=1.
- Idle scan, no keys: row_n sequence 1110 -> 1101 -> 1011 -> 0111 -> 1110, each value held exactly 4 cycles; key_pressed stays 0.
- Press '5' (row1, col1) and hold -> key_pressed=1, key_code=4'h5 within 17 cycles; row_n stays 4'b1101 while held.
- Release '5' -> key_pressed=0 after 4 consecutive all-high col_s cycles (6 cycles after col_n rises); next row_n=4'b1011.
  - Also: a 2-cycle glitch high then low again clears the release counter and keeps key_pressed=1.
- Press '4' and '6' together (row1, cols 0 and 2):
  - Without macro: key_code=4'h4, key_pressed=1.
  - With KEYPAD_GHOST_REJECT_EN: key_pressed stays 0 and scanning continues.
- Hold '0' (row3, col1), then also press '1' (row0, col0):
  - key_code stays 4'h0 while '0' is held.
  - After '0' is released, the scanner reports key_code=4'h1 within 17 cycles.
  - Asserting reset during this HOLD clears the outputs at once.
